spi_slave_if: RTL and testbench

//  Serial front end for the single-port command RAM. Deserialises SPI frames
//  (mode 0, MSB first) into 10-bit command words {op[1:0],payload[7:0]}.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_tx_serializer.sv | 56 +++++
 rtl/spi_slave_if.sv | 93 +++++++++
 tb/tb_spi_slave_if.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI front end of the command RAM.
package spi_ram_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 8;
  localparam int unsigned RX_W_DEF      = ADDR_SIZE_DEF + 2;
  localparam int unsigned DATA_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads one RAM read word on tx_valid while armed and shifts it out MSB first on MISO.
module spi_tx_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              arm,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
  output logic              done,
  output logic              last
);

  localparam int unsigned CW = $clog2(DATA_W);

  logic [DATA_W-2:0] tx_shift;
  logic [CW-1:0]     cnt;
  logic              busy;

  // Asserted on the edge that retires the final bit; clear (frame abort) overrides it.
  assign last = busy && (cnt == CW'(DATA_W-1)) && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso     <= 1'b0;
      tx_shift <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      miso     <= 1'b0;
      tx_shift <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (busy) begin
      if (cnt == CW'(DATA_W-1)) begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        miso     <= tx_shift[DATA_W-2];
        tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
        cnt      <= cnt + 1'b1;
      end
    end else if (arm && tx_valid) begin
      miso     <= tx_data[DATA_W-1];
      tx_shift <= tx_data[DATA_W-2:0];
      cnt      <= '0;
      busy     <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deserialises command words for the RAM and returns read data on MISO.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  localparam int unsigned RX_W     = ADDR_SIZE + 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [RX_W-1:0]   rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned CNT_W = $clog2(RX_W + 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RX_W-2:0]   rx_shift;
  logic              rd_addr_seen;
  logic              receiving, rx_active, rx_last;
  logic              tx_arm, tx_done, tx_last;

  // bit_cnt parks at RX_W once the word is captured, marking the hold/transmit phase.
  assign receiving = (state == WRITE || state == READ_ADD || state == READ_DATA) && !SS_n;
  assign rx_active = receiving && (bit_cnt != CNT_W'(RX_W));
  assign rx_last   = rx_active && (bit_cnt == CNT_W'(RX_W-1));
  assign tx_arm    = (state == READ_DATA) && !SS_n && (bit_cnt == CNT_W'(RX_W)) && !tx_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_seen) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_active) begin
        rx_shift <= {rx_shift[RX_W-3:0], MOSI};
        bit_cnt  <= bit_cnt + 1'b1;
      end else if (!receiving) begin
        bit_cnt <= '0;
      end
      if (rx_last) begin
        rx_data  <= {rx_shift, MOSI};
        rx_valid <= 1'b1;
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
      end
      if (tx_last) rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (SS_n),
    .arm      (tx_arm),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .miso     (MISO),
    .done     (tx_done),
    .last     (tx_last)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write-frame table plus read, abort and reset sequences.
module tb_spi_slave_if;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_chk  = 0;
  int n_pass = 0;

  spi_slave_if #(
    .ADDR_SIZE (8),
    .DATA_W    (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame from IDLE; returns just after the edge that samples the last payload bit.
  task automatic frame(input logic cmd, input logic [9:0] pl, input string nm);
    logic early;
    early = 1'b0;
    SS_n = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = pl[i];
      tick();
      if (i > 0 && rx_valid) early = 1'b1;
    end
    chk({nm, " early_valid"}, 32'(early), 32'd0);
    chk({nm, " rx_valid"}, 32'(rx_valid), 32'd1);
  endtask

  typedef struct {
    logic       cmd;
    logic [9:0] pl;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[4];
  logic [7:0] exp_bits;
  logic       bad;

  initial begin
    tbl[0] = '{1'b0, 10'b00_0000_0101, 10'h005};
    tbl[1] = '{1'b0, 10'b01_1010_1010, 10'h1AA};
    tbl[2] = '{1'b0, 10'b01_1111_1111, 10'h1FF};
    tbl[3] = '{1'b0, 10'b00_0000_0000, 10'h000};

    rstn = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #12;
    chk("reset MISO", 32'(MISO), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    chk("reset state", 32'(dut.state), 32'(IDLE));
    rstn = 1'b1;
    tick();

    // Write frames
    foreach (tbl[k]) begin
      frame(tbl[k].cmd, tbl[k].pl, $sformatf("wr%0d", k));
      chk($sformatf("wr%0d rx_data", k), 32'(rx_data), 32'(tbl[k].exp));
      tick();
      chk($sformatf("wr%0d valid_fall", k), 32'(rx_valid), 32'd0);
      for (int j = 0; j < 3; j++) begin
        MOSI = ~MOSI;
        tick();
      end
      chk($sformatf("wr%0d hold", k), 32'(rx_data), 32'(tbl[k].exp));
      chk($sformatf("wr%0d MISO", k), 32'(MISO), 32'd0);
      SS_n = 1'b1;
      tick();
      chk($sformatf("wr%0d idle", k), 32'(dut.state), 32'(IDLE));
    end

    // Read address
    frame(1'b1, 10'b10_0000_0101, "rdaddr");
    chk("rdaddr rx_data", 32'(rx_data), 32'h205);
    chk("rdaddr seen", 32'(dut.rd_addr_seen), 32'd1);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tick();
    chk("rdaddr MISO", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    SS_n = 1'b1;
    tick();

    // Read data, RAM answers one cycle after rx_valid
    frame(1'b1, 10'b11_0000_0000, "rddata");
    chk("rddata rx_data", 32'(rx_data), 32'h300);
    tick();
    chk("rddata MISO pre", 32'(MISO), 32'd0);
    tx_valid = 1'b1; tx_data = 8'hA5;
    exp_bits = 8'b1010_0101;
    for (int b = 7; b >= 0; b--) begin
      tick();
      tx_valid = 1'b0;
      chk($sformatf("rddata bit%0d", b), 32'(MISO), 32'(exp_bits[b]));
    end
    tick();
    chk("rddata MISO end", 32'(MISO), 32'd0);
    chk("rddata seen_clr", 32'(dut.rd_addr_seen), 32'd0);
    tx_valid = 1'b1;
    tick();
    chk("rddata no_reload", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    SS_n = 1'b1;
    tick();

    // Abort after 4 payload bits
    SS_n = 1'b0;
    tick();
    MOSI = 1'b0;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MOSI = i[0];
      tick();
      if (rx_valid) bad = 1'b1;
    end
    SS_n = 1'b1;
    tick();
    if (rx_valid) bad = 1'b1;
    chk("abort no_valid", 32'(bad), 32'd0);
    chk("abort idle", 32'(dut.state), 32'(IDLE));
    chk("abort rx_data", 32'(rx_data), 32'h300);
    frame(1'b0, 10'b00_1100_0011, "post_abort");
    chk("post_abort rx_data", 32'(rx_data), 32'h0C3);
    SS_n = 1'b1;
    tick();

    // Read data with no RAM response
    frame(1'b1, 10'b10_1010_0111, "rdaddr2");
    chk("rdaddr2 rx_data", 32'(rx_data), 32'h2A7);
    SS_n = 1'b1;
    tick();
    frame(1'b1, 10'b11_1100_0000, "notx");
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (MISO !== 1'b0) bad = 1'b1;
    end
    chk("notx MISO", 32'(bad), 32'd0);
    chk("notx state", 32'(dut.state), 32'(READ_DATA));
    SS_n = 1'b1;
    tick();
    chk("notx idle", 32'(dut.state), 32'(IDLE));
    chk("notx seen", 32'(dut.rd_addr_seen), 32'd1);

    // Asynchronous reset in the middle of a transmit
    frame(1'b1, 10'b11_0001_0001, "rst_mid");
    chk("rst_mid rx_data", 32'(rx_data), 32'h311);
    tick();
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0;
    chk("rst_mid bit7", 32'(MISO), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid MISO", 32'(MISO), 32'd0);
    chk("rst_mid rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid rx_data", 32'(rx_data), 32'd0);
    chk("rst_mid state", 32'(dut.state), 32'(IDLE));
    chk("rst_mid seen", 32'(dut.rd_addr_seen), 32'd0);
    SS_n = 1'b1;
    #2;
    rstn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
